// File: rtl/ctrl_pkg.sv
// Shared constants for the bus-computer control sequencer: opcodes, control-word
// bit positions and the default microstep count.
package ctrl_pkg;

    localparam int unsigned DEF_N     = 8;
    localparam int unsigned DEF_OPW   = 4;
    localparam int unsigned DEF_STEPS = 5;
    localparam int unsigned CW        = 16;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    // Control-word bit positions, hlt at the MSB down to fi at the LSB
    localparam int unsigned B_HLT = 15;
    localparam int unsigned B_MI  = 14;
    localparam int unsigned B_RI  = 13;
    localparam int unsigned B_RO  = 12;
    localparam int unsigned B_IO  = 11;
    localparam int unsigned B_II  = 10;
    localparam int unsigned B_AI  = 9;
    localparam int unsigned B_AO  = 8;
    localparam int unsigned B_EO  = 7;
    localparam int unsigned B_SU  = 6;
    localparam int unsigned B_BI  = 5;
    localparam int unsigned B_OI  = 4;
    localparam int unsigned B_CE  = 3;
    localparam int unsigned B_CO  = 2;
    localparam int unsigned B_J   = 1;
    localparam int unsigned B_FI  = 0;

    // One-hot control word with only the given line set
    function automatic logic [CW-1:0] cbit(input int unsigned idx);
        return CW'(1) << idx;
    endfunction

endpackage

// File: rtl/microcode_rom.sv
// Combinational microcode: maps (opcode, microstep, flags) to the 16-bit control word.
module microcode_rom
    import ctrl_pkg::*;
#(
    parameter int unsigned OPW = DEF_OPW,
    parameter int unsigned SW  = 3
) (
    input  logic [OPW-1:0] i_opcode,
    input  logic [SW-1:0]  i_step,
    input  logic           i_cf,
    input  logic           i_zf,
    output logic [CW-1:0]  o_word
);

    logic [3:0] w_op;
    assign w_op = 4'(i_opcode);

    // Fetch words for T0/T1, then per-opcode execute words for T2..T4
    always_comb begin
        o_word = '0;
        if (i_step == SW'(0)) begin
            o_word = cbit(B_CO) | cbit(B_MI);
        end else if (i_step == SW'(1)) begin
            o_word = cbit(B_RO) | cbit(B_II) | cbit(B_CE);
        end else begin
            case (w_op)
                OP_LDA: begin
                    if (i_step == SW'(2)) o_word = cbit(B_IO) | cbit(B_MI);
                    if (i_step == SW'(3)) o_word = cbit(B_RO) | cbit(B_AI);
                end
                OP_ADD, OP_SUB: begin
                    if (i_step == SW'(2)) o_word = cbit(B_IO) | cbit(B_MI);
                    if (i_step == SW'(3)) o_word = cbit(B_RO) | cbit(B_BI);
                    if (i_step == SW'(4)) begin
                        o_word = cbit(B_EO) | cbit(B_AI) | cbit(B_FI);
                        if (w_op == OP_SUB) o_word = o_word | cbit(B_SU);
                    end
                end
                OP_STA: begin
                    if (i_step == SW'(2)) o_word = cbit(B_IO) | cbit(B_MI);
                    if (i_step == SW'(3)) o_word = cbit(B_AO) | cbit(B_RI);
                end
                OP_LDI: begin
                    if (i_step == SW'(2)) o_word = cbit(B_IO) | cbit(B_AI);
                end
                OP_JMP: begin
                    if (i_step == SW'(2)) o_word = cbit(B_IO) | cbit(B_J);
                end
                OP_JC: begin
                    if (i_step == SW'(2) && i_cf) o_word = cbit(B_IO) | cbit(B_J);
                end
                OP_JZ: begin
                    if (i_step == SW'(2) && i_zf) o_word = cbit(B_IO) | cbit(B_J);
                end
                OP_OUT: begin
                    if (i_step == SW'(2)) o_word = cbit(B_AO) | cbit(B_OI);
                end
                OP_HLT: begin
                    if (i_step == SW'(2)) o_word = cbit(B_HLT);
                end
                default: o_word = '0;
            endcase
        end
    end

endmodule

// File: rtl/control_sequencer.sv
// Microstep counter and halt latch driving the bus computer's sixteen control lines.
module control_sequencer
    import ctrl_pkg::*;
#(
    parameter int unsigned N     = DEF_N,
    parameter int unsigned OPW   = DEF_OPW,
    parameter int unsigned STEPS = DEF_STEPS
) (
    input  logic                       clk,
    input  logic                       clr_,
    input  logic [N-1:0]               irval,
    input  logic                       cf,
    input  logic                       zf,
    input  logic                       prog,
    output logic                       hlt,
    output logic                       mi,
    output logic                       ri,
    output logic                       ro,
    output logic                       io,
    output logic                       ii,
    output logic                       ai,
    output logic                       ao,
    output logic                       eo,
    output logic                       su,
    output logic                       bi,
    output logic                       oi,
    output logic                       ce,
    output logic                       co,
    output logic                       j,
    output logic                       fi,
    output logic [$clog2(STEPS)-1:0]   step,
    output logic                       halted
);

    localparam int unsigned SW = $clog2(STEPS);

    logic [SW-1:0]  r_step;
    logic           r_halted;
    logic [OPW-1:0] w_opcode;
    logic [CW-1:0]  w_word;
    logic [CW-1:0]  w_ctrl;
    logic           w_unused_operand;

    assign w_opcode         = irval[N-1 -: OPW];
    assign w_unused_operand = ^irval[N-OPW-1:0];

    microcode_rom #(
        .OPW (OPW),
        .SW  (SW)
    ) u_rom (
        .i_opcode (w_opcode),
        .i_step   (r_step),
        .i_cf     (cf),
        .i_zf     (zf),
        .o_word   (w_word)
    );

    // Step advance with early termination on an empty word, wrap and halt freeze
    always_ff @(posedge clk or negedge clr_) begin
        if (!clr_) begin
            r_step   <= '0;
            r_halted <= 1'b0;
        end else if (!prog) begin
            r_step   <= '0;
        end else if (!r_halted) begin
            if (w_word[B_HLT]) begin
                r_halted <= 1'b1;
            end else if (r_step == SW'(STEPS - 1) ||
                         (r_step >= SW'(2) && w_word == '0)) begin
                r_step <= '0;
            end else begin
                r_step <= r_step + SW'(1);
            end
        end
    end

    // Gate the word: reset and manual mode force all-zero, a halted machine shows only hlt
    always_comb begin
        w_ctrl = '0;
        if (clr_ && prog) begin
            w_ctrl = r_halted ? cbit(B_HLT) : w_word;
        end
    end

    assign hlt    = w_ctrl[B_HLT];
    assign mi     = w_ctrl[B_MI];
    assign ri     = w_ctrl[B_RI];
    assign ro     = w_ctrl[B_RO];
    assign io     = w_ctrl[B_IO];
    assign ii     = w_ctrl[B_II];
    assign ai     = w_ctrl[B_AI];
    assign ao     = w_ctrl[B_AO];
    assign eo     = w_ctrl[B_EO];
    assign su     = w_ctrl[B_SU];
    assign bi     = w_ctrl[B_BI];
    assign oi     = w_ctrl[B_OI];
    assign ce     = w_ctrl[B_CE];
    assign co     = w_ctrl[B_CO];
    assign j      = w_ctrl[B_J];
    assign fi     = w_ctrl[B_FI];
    assign step   = r_step;
    assign halted = r_halted;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: vector table, directed corner sequences and a randomized
// instruction stream checked against a list-based model of the microprogram.
module tb_control_sequencer;

    localparam logic [15:0] HLT = 16'h8000, MI = 16'h4000, RI = 16'h2000, RO = 16'h1000;
    localparam logic [15:0] IO  = 16'h0800, II = 16'h0400, AI = 16'h0200, AO = 16'h0100;
    localparam logic [15:0] EO  = 16'h0080, SU = 16'h0040, BI = 16'h0020, OI = 16'h0010;
    localparam logic [15:0] CE  = 16'h0008, CO = 16'h0004, J  = 16'h0002, FI = 16'h0001;
    localparam logic [15:0] F0  = CO | MI;
    localparam logic [15:0] F1  = RO | II | CE;

    logic       clk = 1'b0;
    logic       clr_, cf, zf, prog;
    logic [7:0] irval;
    logic       hlt, mi, ri, ro, io, ii, ai, ao, eo, su, bi, oi, ce, co, j, fi;
    logic [2:0] step;
    logic       halted;
    logic [15:0] w_out;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign w_out = {hlt, mi, ri, ro, io, ii, ai, ao, eo, su, bi, oi, ce, co, j, fi};

    control_sequencer dut (
        .clk (clk), .clr_ (clr_), .irval (irval), .cf (cf), .zf (zf), .prog (prog),
        .hlt (hlt), .mi (mi), .ri (ri), .ro (ro), .io (io), .ii (ii), .ai (ai), .ao (ao),
        .eo (eo), .su (su), .bi (bi), .oi (oi), .ce (ce), .co (co), .j (j), .fi (fi),
        .step (step), .halted (halted)
    );

    typedef struct {
        logic [7:0]  ir;
        logic        c;
        logic        z;
        int          st;
        logic [15:0] w;
    } vec_t;

    typedef logic [15:0] wq_t[$];

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Check step/word/halted at the negedge, then move to just after the next posedge
    task automatic run_chk(input string nm, input int st, input logic [15:0] w,
                           input logic h);
        @(negedge clk);
        chk({nm, ".step"}, 32'(step), 32'(st));
        chk({nm, ".word"}, 32'(w_out), 32'(w));
        chk({nm, ".halted"}, 32'(halted), 32'(h));
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic [7:0] ir, input logic c, input logic z, input int st,
                       input logic [15:0] w);
        vec_t v;
        v.ir = ir; v.c = c; v.z = z; v.st = st; v.w = w;
        tbl.push_back(v);
    endtask

    // Execute-phase words of an instruction, listing only the steps that do something
    function automatic wq_t micro(input logic [3:0] op, input logic c, input logic z);
        wq_t q;
        q = {};
        case (op)
            4'h1: q = '{IO | MI, RO | AI};
            4'h2: q = '{IO | MI, RO | BI, EO | AI | FI};
            4'h3: q = '{IO | MI, RO | BI, EO | SU | AI | FI};
            4'h4: q = '{IO | MI, AO | RI};
            4'h5: q = '{IO | AI};
            4'h6: q = '{IO | J};
            4'h7: if (c) q = '{IO | J};
            4'h8: if (z) q = '{IO | J};
            4'hE: q = '{AO | OI};
            4'hF: q = '{HLT};
            default: q = {};
        endcase
        return q;
    endfunction

    initial begin
        wq_t sched;
        wq_t ex;
        logic [3:0] op;
        bit aborted;

        clr_ = 1'b0; prog = 1'b1; irval = 8'h00; cf = 1'b0; zf = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.word", 32'(w_out), 32'h0);
        chk("reset.step", 32'(step), 32'h0);
        chk("reset.halted", 32'(halted), 32'h0);
        clr_ = 1'b1;
        #1;
        chk("release.word", 32'(w_out), 32'(F0));

        // Vector table: one row per cycle of a straight-line instruction stream
        add(8'h00, 0, 0, 0, F0); add(8'h00, 0, 0, 1, F1); add(8'h00, 0, 0, 2, 16'h0);
        add(8'h2E, 0, 0, 0, F0); add(8'h2E, 0, 0, 1, F1); add(8'h2E, 0, 0, 2, IO | MI);
        add(8'h2E, 0, 0, 3, RO | BI); add(8'h2E, 0, 0, 4, EO | AI | FI);
        add(8'h3E, 0, 0, 0, F0); add(8'h3E, 0, 0, 1, F1); add(8'h3E, 0, 0, 2, IO | MI);
        add(8'h3E, 0, 0, 3, RO | BI); add(8'h3E, 0, 0, 4, EO | SU | AI | FI);
        add(8'h75, 1, 0, 0, F0); add(8'h75, 1, 0, 1, F1); add(8'h75, 1, 0, 2, IO | J);
        add(8'h75, 1, 0, 3, 16'h0);
        add(8'h75, 0, 1, 0, F0); add(8'h75, 0, 1, 1, F1); add(8'h75, 0, 1, 2, 16'h0);
        add(8'h85, 0, 1, 0, F0); add(8'h85, 0, 1, 1, F1); add(8'h85, 0, 1, 2, IO | J);
        add(8'h85, 0, 1, 3, 16'h0);
        add(8'h85, 1, 0, 0, F0); add(8'h85, 1, 0, 1, F1); add(8'h85, 1, 0, 2, 16'h0);
        add(8'h14, 0, 0, 0, F0); add(8'h14, 0, 0, 1, F1); add(8'h14, 0, 0, 2, IO | MI);
        add(8'h14, 0, 0, 3, RO | AI); add(8'h14, 0, 0, 4, 16'h0);
        add(8'h47, 0, 0, 0, F0); add(8'h47, 0, 0, 1, F1); add(8'h47, 0, 0, 2, IO | MI);
        add(8'h47, 0, 0, 3, AO | RI); add(8'h47, 0, 0, 4, 16'h0);
        add(8'h5A, 0, 0, 0, F0); add(8'h5A, 0, 0, 1, F1); add(8'h5A, 0, 0, 2, IO | AI);
        add(8'h5A, 0, 0, 3, 16'h0);
        add(8'h63, 0, 0, 0, F0); add(8'h63, 0, 0, 1, F1); add(8'h63, 0, 0, 2, IO | J);
        add(8'h63, 0, 0, 3, 16'h0);
        add(8'hE0, 0, 0, 0, F0); add(8'hE0, 0, 0, 1, F1); add(8'hE0, 0, 0, 2, AO | OI);
        add(8'hE0, 0, 0, 3, 16'h0);
        add(8'hA1, 1, 1, 0, F0); add(8'hA1, 1, 1, 1, F1); add(8'hA1, 1, 1, 2, 16'h0);
        add(8'h00, 0, 0, 0, F0);

        for (int i = 0; i < tbl.size(); i++) begin
            irval = tbl[i].ir; cf = tbl[i].c; zf = tbl[i].z;
            run_chk($sformatf("tbl[%0d]", i), tbl[i].st, tbl[i].w, 1'b0);
        end

        // Mid-LDA asynchronous reset at T3; now at T1 of the next instruction
        irval = 8'h14;
        run_chk("lda.t1", 1, F1, 1'b0);
        run_chk("lda.t2", 2, IO | MI, 1'b0);
        #1 clr_ = 1'b0;
        #1;
        chk("lda_rst.word", 32'(w_out), 32'h0);
        chk("lda_rst.step", 32'(step), 32'h0);
        clr_ = 1'b1;
        #1;
        chk("lda_rel.word", 32'(w_out), 32'(F0));
        run_chk("lda_rel.t0", 0, F0, 1'b0);

        // prog=0 during ADD T3
        irval = 8'h2E;
        run_chk("pg.t1", 1, F1, 1'b0);
        run_chk("pg.t2", 2, IO | MI, 1'b0);
        prog = 1'b0;
        #1;
        chk("pg.off_word", 32'(w_out), 32'h0);
        run_chk("pg.off0", 3, 16'h0, 1'b0);
        for (int k = 0; k < 4; k++) run_chk($sformatf("pg.off%0d", k + 1), 0, 16'h0, 1'b0);
        prog = 1'b1;
        run_chk("pg.t0", 0, F0, 1'b0);
        run_chk("pg.t1b", 1, F1, 1'b0);
        run_chk("pg.t2b", 2, IO | MI, 1'b0);
        run_chk("pg.t3b", 3, RO | BI, 1'b0);
        run_chk("pg.t4b", 4, EO | AI | FI, 1'b0);

        // Halt: freeze at T2 with only hlt, hold through prog=0, clear by reset
        irval = 8'hF0;
        run_chk("h.t0", 0, F0, 1'b0);
        run_chk("h.t1", 1, F1, 1'b0);
        run_chk("h.t2", 2, HLT, 1'b0);
        for (int k = 0; k < 12; k++) run_chk($sformatf("h.hold%0d", k), 2, HLT, 1'b1);
        prog = 1'b0;
        run_chk("h.prog0a", 2, 16'h0, 1'b1);
        run_chk("h.prog0b", 0, 16'h0, 1'b1);
        prog = 1'b1;
        run_chk("h.prog1", 0, HLT, 1'b1);
        #1 clr_ = 1'b0;
        #1;
        chk("h.rst_word", 32'(w_out), 32'h0);
        chk("h.rst_step", 32'(step), 32'h0);
        chk("h.rst_halted", 32'(halted), 32'h0);
        clr_ = 1'b1; irval = 8'h00;
        #1;
        chk("h.rel_word", 32'(w_out), 32'(F0));
        run_chk("h.rel_t0", 0, F0, 1'b0);
        run_chk("h.rel_t1", 1, F1, 1'b0);
        run_chk("h.rel_t2", 2, 16'h0, 1'b0);

        // Randomized stream against the list model; prog occasionally dropped mid-instruction
        for (int n = 0; n < 150; n++) begin
            op = 4'($urandom_range(0, 14));
            irval = {op, 4'($urandom)};
            cf = 1'($urandom); zf = 1'($urandom);
            ex = micro(op, cf, zf);
            sched = '{F0, F1};
            foreach (ex[k]) sched.push_back(ex[k]);
            if (ex.size() < 3) sched.push_back(16'h0);
            aborted = 1'b0;
            for (int i = 0; i < sched.size() && !aborted; i++) begin
                if (i > 0 && $urandom_range(0, 24) == 0) begin
                    prog = 1'b0;
                    run_chk($sformatf("rnd%0d.abort", n), i, 16'h0, 1'b0);
                    run_chk($sformatf("rnd%0d.idle", n), 0, 16'h0, 1'b0);
                    prog = 1'b1;
                    aborted = 1'b1;
                end else begin
                    run_chk($sformatf("rnd%0d.op%0h.s%0d", n, op, i), i, sched[i], 1'b0);
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Microcoded control unit for the 8-bit bus computer. It takes the opcode nibble from the instruction register and the registered carry and zero flags. From these it drives the sixteen active-high control lines (hlt, mi, ri, ro, io, ii, ai, ao, eo, su, bi, oi, ce, co, j, fi) into the registers, ALU/flags, MAR, RAM, program counter and output register. Internally it is a microstep counter plus a halt latch, and all control lines are decoded from that state.

## Interface
- N, 8, data/instruction width; the opcode is irval[N-1:N-OPW]
- OPW, 4, opcode width
- STEPS, 5, microsteps per instruction (T0..T4); the step counter is $clog2(STEPS) bits wide
- clk  input  1  system clock; all state changes on posedge
- clr_  input  1  asynchronous, active-low reset
- irval  input  N  instruction register contents
- cf  input  1  registered carry flag
- zf  input  1  registered zero flag
- prog  input  1  0 = manual-program mode (sequencer idle), 1 = run
- hlt, mi, ri, ro, io, ii, ai, ao, eo, su, bi, oi, ce, co, j, fi  output  1 each  control lines, active high
- step  output  $clog2(STEPS)  current microstep, for LEDs
- halted  output  1  halt latch state

## Operation
- **Fetch, common to all opcodes**
  - T0: co, mi
  - T1: ro, ii, ce
- **Execute steps (T2, T3, T4)**
  - 0x0 NOP: none
  - 0x1 LDA: io,mi / ro,ai
  - 0x2 ADD: io,mi / ro,bi / eo,ai,fi
  - 0x3 SUB: io,mi / ro,bi / eo,su,ai,fi
  - 0x4 STA: io,mi / ao,ri
  - 0x5 LDI: io,ai
  - 0x6 JMP: io,j
  - 0x7 JC: io,j if cf=1, else none
  - 0x8 JZ: io,j if zf=1, else none
  - 0xE OUT: ao,oi
  - 0xF HLT: hlt
  - 0x9–0xD: behave as NOP
- **Early termination:** at any step ≥2 whose decoded word is all-zero, the next step is T0 and not step+1. This covers NOP, untaken JC/JZ, and the tail steps of short instructions.
- **Wrap:** from T(STEPS-1), the next step is T0.
- **Halt:** if the decoded word has hlt set at a posedge, halted←1 and step freezes. While halted=1:
  - hlt=1 and every other line is 0.
  - Only reset clears halted.
- **prog=0:**
  - All control outputs are 0.
  - step is held at 0.
  - halted is held at its current value.
- **Reset (clr_ low), any time including mid-instruction:**
  - step=0, halted=0, all control outputs 0 (forced combinationally while clr_ is low).
  - After release with prog=1, the outputs show T0 (co, mi) immediately.

## Timing
- Control outputs are combinational from (step, opcode, cf, zf, halted, prog, clr_). No extra latency: the word for step k is valid for the whole cycle, and the destination registers capture on the posedge that ends it.
- step/halted update on posedge clk. Reset is asynchronous.
- Flags are read combinationally during the JC/JZ T2 cycle. cf/zf must already be registered, since fi updates them only at the end of an ADD/SUB T4.
- Instruction lengths in cycles:
  - 3: NOP, untaken JC/JZ, unused opcodes
  - 4: LDI, JMP, taken JC/JZ, OUT
  - 5: LDA, STA
  - 5 (no early-termination cycle): ADD, SUB
- prog changing mid-instruction: a 1→0 change forces step to 0 at the next posedge, and the interrupted instruction is discarded.

## Structure
- Package ctrl_pkg holds:
  - opcode localparams (OP_NOP … OP_HLT)
  - control-bit index localparams in the fixed order hlt, mi, ri, ro, io, ii, ai, ao, eo, su, bi, oi, ce, co, j, fi (bit 15 → 0)
  - the STEPS default
- Sub-module microcode_rom is purely combinational: (opcode, step, cf, zf) → 16-bit control word.
- control_sequencer contains:
  - the step counter
  - the halt latch
  - the prog/reset gating
  - the unpacking of the control word onto named ports

## Test plan
- Reset, then prog=1, irval=0x00: step sequence 0,1,2,0,1…; T0 shows co,mi only; T1 shows ro,ii,ce only; T2 word is zero.
- irval=0x2E, cf=0, zf=0: T2 io,mi; T3 ro,bi; T4 eo,ai,fi. irval=0x3E at T4 adds su. Both return to T0 after T4.
- irval=0x75: cf=1 → T2 io,j, then T0 in 4 cycles; cf=0 → no lines at T2, then T0 in 3 cycles. Repeat with 0x85 and zf.
- irval=0xF0: T2 asserts hlt; halted=1 and step stays 2 for 10+ cycles with only hlt high. Pulsing clr_ low gives step=0, halted=0, all lines 0.
- Mid-LDA reset: assert clr_ low at T3, asynchronously between edges → outputs 0 at once; after release, the T0 word appears with no posedge needed.
- prog=0 for 5 cycles during ADD T3 → all lines 0 and step=0; after prog=1, fetch restarts at T0.
